ins_mem_banked: RTL
===================

Name: ins_mem_banked

Overview:
Synchronous, loadable, multi-bank instruction memory. It replaces the hard-coded combinational program ROM ahead of the IF stage.
- Holds NUM_BANKS independent program images of DEPTH words each.
- Programs are written through a load port; the active bank is selected per fetch.
- Fetch returns a registered instruction with 1-cycle latency, supports a pipeline stall, and flags bad PCs.
- After reset, a clear sequencer fills every word with DEFAULT_INSTR before fetches are accepted.

Parameters:
DATA_W, 32, instruction width in bits
PC_W, 32, byte-address width of pc_pi
DEPTH, 64, words per bank (power of 2, ≥4)
NUM_BANKS, 4, number of program images (power of 2, ≥1)
DEFAULT_INSTR, 32'h00000000, fill value; also returned on fetch error

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
fetch_req_pi  in  1  fetch request this cycle
pc_pi  in  PC_W  byte address of the fetch
bank_sel_pi  in  clog2(NUM_BANKS) bank used by this fetch (min width 1)
stall_pi  in  1  hold the current output; ignore fetch_req_pi
load_en_pi  in  1  write one word
load_bank_pi  in  clog2(NUM_BANKS) bank to write
load_addr_pi  in  clog2(DEPTH) word index to write
load_data_pi  in  DATA_W  word to write
instruction_po  out  DATA_W  fetched instruction
ins_valid_po  out  1  instruction_po is valid
fetch_err_po  out  2  2'b00 ok, 2'b01 misaligned, 2'b10 out of range
busy_po  out  1  clear sequencer active; fetches and loads are ignored

Behaviour:
- Reset, sampled at the clock edge:
  - instruction_po = DEFAULT_INSTR, ins_valid_po = 0, fetch_err_po = 0, busy_po = 1.
  - FSM enters CLEAR with clr_ptr = 0.
  - Reset asserted mid-CLEAR or mid-READY restarts CLEAR from 0.
- FSM state CLEAR:
  - Each cycle writes DEFAULT_INSTR to the flat word clr_ptr (bank = clr_ptr / DEPTH) and increments clr_ptr.
  - After writing word NUM_BANKS*DEPTH-1, the FSM moves to READY. busy_po goes 0 on the cycle READY is entered.
  - CLEAR lasts exactly NUM_BANKS*DEPTH cycles.
  - During CLEAR, fetch_req_pi and load_en_pi are ignored and ins_valid_po = 0.
- FSM state READY: stays in READY until reset.
- Fetch (READY, stall_pi = 0, fetch_req_pi = 1):
  - Word index = pc_pi >> 2.
  - pc_pi[1:0] != 0 gives err 01. Otherwise, index ≥ DEPTH gives err 10. Misaligned has priority over out of range.
  - If there is no error, instruction_po = mem[bank_sel_pi][index]; on error, instruction_po = DEFAULT_INSTR.
  - The result appears on the next edge with ins_valid_po = 1 and fetch_err_po set.
  - Latency is 1 cycle, with a throughput of 1 fetch per cycle.
- No request (READY, stall_pi = 0, fetch_req_pi = 0): ins_valid_po = 0 and fetch_err_po = 0 next cycle; instruction_po holds.
- Stall (stall_pi = 1): instruction_po, ins_valid_po and fetch_err_po all hold their values; the fetch request is dropped. Loads still proceed.
- Load (READY, load_en_pi = 1): mem[load_bank_pi][load_addr_pi] = load_data_pi at the edge.
- Same-word load and fetch in the same cycle: write-first, so the fetch returns load_data_pi.
- A load to a different bank from the fetch bank does not affect the fetch.
- Debug display: a $display of time, bank, PC and instruction is printed on each valid fetch, in simulation only.

Decomposition:
- Shared package ins_mem_pkg holds:
  - fetch error codes FE_OK / FE_MISALIGN / FE_RANGE;
  - FSM state enum CLEAR / READY;
  - the HALT (32'h28000000) and NOP (32'h0) opcode constants.
- One sub-module, ins_mem_array: a NUM_BANKS*DEPTH x DATA_W single-write-port, single-read-port RAM with write-first bypass.
- The FSM, error decode and output register live in the top level.

Test Plan:
- Reset, then hold fetch_req_pi = 1, pc = 0 → busy_po = 1 for exactly 256 cycles (4×64), ins_valid_po = 0 throughout; the first valid fetch returns 32'h0.
- Load bank 0 words 0–7 with the summation program (15080005, 10200000, …, 28000000). Fetch pc = 0,4,…,28 back-to-back → the matching words appear 1 cycle after each request with err 00.
- Load bank 1 word 0 = 32'h28000000. Fetch pc = 0 with bank_sel 0, then with bank_sel 1 → 15080005, then 28000000.
- Fetch pc = 6 → err 01, instruction 0. Fetch pc = 256 → err 10. Fetch pc = 258 → err 01 (misaligned priority).
- Fetch pc = 8 with stall_pi = 1 for 3 cycles, then released → output holds the previous word for 3 cycles; the pc = 8 word appears 1 cycle after the release.
- Same-cycle load and fetch of bank 0 word 2 with data DEADBEEF → DEADBEEF is returned. Assert reset mid-run → busy_po = 1 again and the next valid fetch returns 0.

Source files
------------

// File: rtl/ins_mem_pkg.sv
// Shared types and constants for the banked instruction memory.
package ins_mem_pkg;

  typedef enum logic [1:0] {
    FE_OK       = 2'b00,
    FE_MISALIGN = 2'b01,
    FE_RANGE    = 2'b10
  } fetch_err_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ins_mem_state_e;

  localparam logic [31:0] HALT = 32'h28000000;
  localparam logic [31:0] NOP  = 32'h00000000;

endpackage

// File: rtl/ins_mem_array.sv
// Flat single-write, single-read word RAM; a same-address write is forwarded to the read.
module ins_mem_array #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 256,
  parameter int AW     = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];

endmodule

// File: rtl/ins_mem_banked.sv
// Loadable multi-bank instruction memory: clear sequencer, fetch error decode and
// registered 1-cycle fetch output with stall.
module ins_mem_banked
  import ins_mem_pkg::*;
#(
  parameter int              DATA_W        = 32,
  parameter int              PC_W          = 32,
  parameter int              DEPTH         = 64,
  parameter int              NUM_BANKS     = 4,
  parameter logic [DATA_W-1:0] DEFAULT_INSTR = '0,
  parameter int              BANK_W        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int              IDX_W         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req_pi,
  input  logic [PC_W-1:0]   pc_pi,
  input  logic [BANK_W-1:0] bank_sel_pi,
  input  logic              stall_pi,
  input  logic              load_en_pi,
  input  logic [BANK_W-1:0] load_bank_pi,
  input  logic [IDX_W-1:0]  load_addr_pi,
  input  logic [DATA_W-1:0] load_data_pi,
  output logic [DATA_W-1:0] instruction_po,
  output logic              ins_valid_po,
  output logic [1:0]        fetch_err_po,
  output logic              busy_po
);

  localparam int WORDS = NUM_BANKS * DEPTH;
  localparam int AW    = $clog2(WORDS);

  ins_mem_state_e    state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  fetch_err_e        err_q;

  logic [IDX_W-1:0]  fetch_idx;
  logic [AW-1:0]     fetch_flat, load_flat;
  fetch_err_e        fetch_err;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata, rdata;

  // DEPTH is a power of two, so any PC bit above the word index means out of range.
  assign fetch_idx = pc_pi[IDX_W+1:2];
  always_comb begin
    fetch_err = FE_OK;
    if (pc_pi[1:0] != 2'b00) fetch_err = FE_MISALIGN;
    else if (|pc_pi[PC_W-1:IDX_W+2]) fetch_err = FE_RANGE;
  end

  if (NUM_BANKS > 1) begin : g_banked
    assign fetch_flat = {bank_sel_pi, fetch_idx};
    assign load_flat  = {load_bank_pi, load_addr_pi};
  end else begin : g_single
    assign fetch_flat = fetch_idx;
    assign load_flat  = load_addr_pi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // The clear sequencer owns the write port until every word has been filled.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    we        = 1'b0;
    waddr     = load_flat;
    wdata     = load_data_pi;
    case (state_q)
      CLEAR: begin
        we        = 1'b1;
        waddr     = clr_ptr_q;
        wdata     = DEFAULT_INSTR;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (&clr_ptr_q) state_d = READY;
      end
      READY:   we = load_en_pi;
      default: state_d = CLEAR;
    endcase
    if (reset) we = 1'b0;
  end

  ins_mem_array #(
    .DATA_W(DATA_W),
    .WORDS (WORDS),
    .AW    (AW)
  ) u_array (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(wdata),
    .raddr_i(fetch_flat),
    .rdata_o(rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= DEFAULT_INSTR;
      valid_q <= 1'b0;
      err_q   <= FE_OK;
    end else if (state_q == CLEAR) begin
      valid_q <= 1'b0;
      err_q   <= FE_OK;
    end else if (!stall_pi) begin
      valid_q <= fetch_req_pi;
      if (fetch_req_pi) begin
        err_q   <= fetch_err;
        instr_q <= (fetch_err == FE_OK) ? rdata : DEFAULT_INSTR;
      end else begin
        err_q <= FE_OK;
      end
    end
  end

  assign instruction_po = instr_q;
  assign ins_valid_po   = valid_q;
  assign fetch_err_po   = err_q;
  assign busy_po        = (state_q == CLEAR);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && state_q == READY && !stall_pi && fetch_req_pi) begin
      $display("[%0t] ins_mem fetch bank=%0d pc=0x%08h instr=0x%08h err=%0d", $time,
               bank_sel_pi, pc_pi, (fetch_err == FE_OK) ? rdata : DEFAULT_INSTR, fetch_err);
    end
  end
`endif

endmodule
